// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command frame parser.
// Holds the parser states, the frame field widths and the checksum helper.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_CH,
      GET_CODE,
      GET_CHK,
      SEND,
      WAIT_ACK,
      WAIT_DONE
   } state_e;

   localparam int CH_MAX = 3;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int CH_W = 2;
   localparam int CODE_W = 8;
   localparam int WORD_W = CH_W + CODE_W;

   function automatic logic [7:0] frame_chk(
      input logic [7:0] sync,
      input logic [7:0] ch,
      input logic [7:0] code
   );
      return sync ^ ch ^ code;
   endfunction

endpackage

// File: rtl/rx_strobe_edge.sv
// rx_strobe_edge: turns the receiver "byte ready" level into a one-cycle
// strobe and presents the byte, optionally bit-mirrored.
module rx_strobe_edge #(
   parameter bit REVERSE_BITS = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       byte_stb,
   output logic [7:0] rx_byte
);

   logic       valid_q;
   logic [7:0] rev;

   // previous rx_valid level, so a held level yields only one byte
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) valid_q <= 1'b0;
      else          valid_q <= rx_valid;
   end

   // bit mirror of the receiver byte
   always_comb begin
      rev = '0;
      for (int i = 0; i < 8; i++) rev[i] = rx_data[7-i];
   end

   assign byte_stb = rx_valid & ~valid_q;
   assign rx_byte  = REVERSE_BITS ? rev : rx_data;

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: validates SYNC/CH/CODE/CHK frames from the UART and
// hands {channel, code} to the SPI transmitter, tracking its chip-select.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter bit         REVERSE_BITS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              spi_cs_n,
   output logic [WORD_W-1:0] spi_data,
   output logic              spi_start,
   output logic              frame_ok,
   output logic              frame_err,
   output logic [7:0]        err_cnt,
   output logic [7:0]        last_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_e state, state_n;

   logic              byte_stb;
   logic [7:0]        rx_byte;
   logic [CH_W-1:0]   ch_q;
   logic [CODE_W-1:0] code_q;
   logic [TW-1:0]     tmo_cnt;
   logic              tmo_hit;
   logic              ld_ch, ld_code, ok, start, err;

   rx_strobe_edge #(
      .REVERSE_BITS (REVERSE_BITS)
   ) u_rx (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .byte_stb (byte_stb),
      .rx_byte  (rx_byte)
   );

   assign tmo_hit = (state != IDLE) &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // next state and control strobes; a timeout wins over any byte
   always_comb begin
      state_n = state;
      ld_ch   = 1'b0;
      ld_code = 1'b0;
      ok      = 1'b0;
      start   = 1'b0;
      err     = 1'b0;
      if (tmo_hit) begin
         err     = 1'b1;
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (byte_stb && rx_byte == SYNC_BYTE) state_n = GET_CH;
            end
            GET_CH: begin
               if (byte_stb) begin
                  if (rx_byte <= 8'(CH_MAX)) begin
                     ld_ch   = 1'b1;
                     state_n = GET_CODE;
                  end else begin
                     err     = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
            GET_CODE: begin
               if (byte_stb) begin
                  ld_code = 1'b1;
                  state_n = GET_CHK;
               end
            end
            GET_CHK: begin
               if (byte_stb) begin
                  if (rx_byte == frame_chk(SYNC_BYTE, 8'(ch_q), code_q)) begin
                     ok      = 1'b1;
                     state_n = SEND;
                  end else begin
                     err     = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
            SEND: begin
               if (spi_cs_n) begin
                  start   = 1'b1;
                  state_n = WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!spi_cs_n) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
               if (spi_cs_n) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // gap/handshake timer, restarted on every state change and idle in IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                 tmo_cnt <= '0;
      else if (state == IDLE || state_n != state)  tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + 1'b1;
   end

   // frame fields, output word, status pulses and saturating error count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch_q      <= '0;
         code_q    <= '0;
         spi_data  <= '0;
         last_code <= '0;
         spi_start <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= '0;
      end else begin
         spi_start <= start;
         frame_ok  <= ok;
         frame_err <= err;
         if (ld_ch)   ch_q   <= rx_byte[CH_W-1:0];
         if (ld_code) code_q <= rx_byte;
         if (ok) begin
            spi_data  <= {ch_q, code_q};
            last_code <= code_q;
         end
         if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: scenario tasks drive byte frames and an SPI model;
// expected SPI words are queued on send and checked on each spi_start.
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int T = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       spi_cs_n = 1'b1;

   logic [9:0] spi_data, spi_data_r;
   logic       spi_start, spi_start_r;
   logic       frame_ok, frame_ok_r;
   logic       frame_err, frame_err_r;
   logic [7:0] err_cnt, err_cnt_r;
   logic [7:0] last_code, last_code_r;

   int n_vec = 0, n_bad = 0;
   int n_start = 0, n_ok = 0, n_err = 0;
   int spi_mode = 0;
   int cs_hold = 0;
   bit use_rev = 1'b0;
   logic [9:0] exp_q[$];

   logic       sel_start, sel_ok, sel_err;
   logic [9:0] sel_data;

   assign sel_start = use_rev ? spi_start_r : spi_start;
   assign sel_ok    = use_rev ? frame_ok_r  : frame_ok;
   assign sel_err   = use_rev ? frame_err_r : frame_err;
   assign sel_data  = use_rev ? spi_data_r  : spi_data;

   uart_cmd_parser #(
      .TIMEOUT_CYCLES (T),
      .REVERSE_BITS   (1'b0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .spi_cs_n  (spi_cs_n),
      .spi_data  (spi_data),
      .spi_start (spi_start),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_cnt   (err_cnt),
      .last_code (last_code)
   );

   uart_cmd_parser #(
      .TIMEOUT_CYCLES (T),
      .REVERSE_BITS   (1'b1)
   ) dut_r (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .spi_cs_n  (spi_cs_n),
      .spi_data  (spi_data_r),
      .spi_start (spi_start_r),
      .frame_ok  (frame_ok_r),
      .frame_err (frame_err_r),
      .err_cnt   (err_cnt_r),
      .last_code (last_code_r)
   );

   always #5 clk = ~clk;

   // SPI transmitter model: 0 = auto 20-cycle transfer, 1 = never busy, 2 = stuck busy
   always @(negedge clk) begin
      case (spi_mode)
         0: begin
            if (cs_hold > 0) begin
               cs_hold--;
               spi_cs_n = (cs_hold == 0);
            end else begin
               spi_cs_n = 1'b1;
               if (sel_start && reset_n) begin
                  spi_cs_n = 1'b0;
                  cs_hold = 20;
               end
            end
         end
         1: spi_cs_n = 1'b1;
         default: spi_cs_n = 1'b0;
      endcase
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset_n) begin
         if (sel_start) begin
            n_start++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_start: unexpected spi_start, spi_data=%h", sel_data);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               if (sel_data !== e) begin
                  n_bad++;
                  $display("FAIL sb_data: got %h want %h", sel_data, e);
               end
            end
         end
         if (sel_ok)  n_ok++;
         if (sel_err) n_err++;
      end
   end

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   function automatic state_e cur_state();
      return use_rev ? dut_r.state : dut.state;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = use_rev ? rev8(b) : b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_good(input logic [1:0] ch, input logic [7:0] code);
      logic [7:0] chk;
      chk = 8'hA5 ^ {6'b0, ch} ^ code;
      exp_q.push_back({ch, code});
      send_byte(8'hA5);
      send_byte({6'b0, ch});
      send_byte(code);
      send_byte(chk);
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (cur_state() == IDLE) done = 1'b1;
      end
      n_vec++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s_idle: state %0d never returned to IDLE", tag, cur_state());
      end
   endtask

   task automatic apply_reset();
      rx_valid = 1'b0;
      spi_mode = 0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_vec++;
      if ({spi_data, spi_start, frame_ok, frame_err, err_cnt, last_code} !== 28'h0) begin
         n_bad++;
         $display("FAIL reset_out: got %h want 0",
                  {spi_data, spi_start, frame_ok, frame_err, err_cnt, last_code});
      end
      n_vec++;
      if (dut.state !== IDLE) begin
         n_bad++;
         $display("FAIL reset_state: got %0d want IDLE", dut.state);
      end
   endtask

   task automatic test_good_frame();
      int s, o, e;
      apply_reset();
      s = n_start; o = n_ok; e = n_err;
      exp_q.push_back(10'h27F);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h7F); send_byte(8'hD8);
      wait_idle("good");
      n_vec++;
      if (n_start - s != 1) begin n_bad++; $display("FAIL good_start: got %0d want 1", n_start - s); end
      n_vec++;
      if (n_ok - o != 1) begin n_bad++; $display("FAIL good_ok: got %0d want 1", n_ok - o); end
      n_vec++;
      if (n_err - e != 0) begin n_bad++; $display("FAIL good_err: got %0d want 0", n_err - e); end
      n_vec++;
      if (spi_data !== 10'h27F) begin n_bad++; $display("FAIL good_data: got %h want 27f", spi_data); end
      n_vec++;
      if (last_code !== 8'h7F) begin n_bad++; $display("FAIL good_code: got %h want 7f", last_code); end
      n_vec++;
      if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL good_errcnt: got %0d want 0", err_cnt); end
   endtask

   task automatic test_bad_checksum();
      int s, o, e;
      apply_reset();
      s = n_start; o = n_ok; e = n_err;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
      repeat (3) @(negedge clk);
      n_vec++;
      if (n_err - e != 1) begin n_bad++; $display("FAIL chk_err: got %0d want 1", n_err - e); end
      n_vec++;
      if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL chk_errcnt: got %0d want 1", err_cnt); end
      n_vec++;
      if (n_start != s || n_ok != o) begin
         n_bad++;
         $display("FAIL chk_nostart: got start %0d ok %0d want 0 0", n_start - s, n_ok - o);
      end
      exp_q.push_back(10'h055);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h55); send_byte(8'hF0);
      wait_idle("chk");
      n_vec++;
      if (n_ok - o != 1) begin n_bad++; $display("FAIL chk_next_ok: got %0d want 1", n_ok - o); end
      n_vec++;
      if (last_code !== 8'h55) begin n_bad++; $display("FAIL chk_next_code: got %h want 55", last_code); end
   endtask

   task automatic test_bad_channel();
      int o, e;
      apply_reset();
      o = n_ok; e = n_err;
      send_byte(8'h00); send_byte(8'hFF);
      n_vec++;
      if (n_err - e != 0) begin n_bad++; $display("FAIL noise_err: got %0d want 0", n_err - e); end
      send_byte(8'hA5);
      @(negedge clk);
      rx_data = 8'h05;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      n_vec++;
      if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ch_err_pulse: got %b want 1", frame_err); end
      @(negedge clk);
      n_vec++;
      if (err_cnt !== 8'd1 || dut.state !== IDLE) begin
         n_bad++;
         $display("FAIL ch_errcnt: got cnt %0d state %0d want 1 IDLE", err_cnt, dut.state);
      end
      send_good(2'd1, 8'h3C);
      wait_idle("ch");
      n_vec++;
      if (n_ok - o != 1 || spi_data !== 10'h13C) begin
         n_bad++;
         $display("FAIL ch_next: got ok %0d data %h want 1 13c", n_ok - o, spi_data);
      end
   endtask

   task automatic test_timeout();
      int s, e;
      apply_reset();
      e = n_err;
      send_byte(8'hA5); send_byte(8'h01);
      repeat (T - 4) @(negedge clk);
      n_vec++;
      if (n_err - e != 0 || dut.state !== GET_CODE) begin
         n_bad++;
         $display("FAIL tmo_early: got err %0d state %0d want 0 GET_CODE", n_err - e, dut.state);
      end
      repeat (6) @(negedge clk);
      n_vec++;
      if (n_err - e != 1 || err_cnt !== 8'd1 || dut.state !== IDLE) begin
         n_bad++;
         $display("FAIL tmo_gap: got err %0d cnt %0d state %0d want 1 1 IDLE",
                  n_err - e, err_cnt, dut.state);
      end
      spi_mode = 1;
      s = n_start; e = n_err;
      send_good(2'd3, 8'hC3);
      repeat (T + 10) @(negedge clk);
      n_vec++;
      if (n_start - s != 1 || n_err - e != 1 || err_cnt !== 8'd2 || dut.state !== IDLE) begin
         n_bad++;
         $display("FAIL tmo_ack: got start %0d err %0d cnt %0d state %0d want 1 1 2 IDLE",
                  n_start - s, n_err - e, err_cnt, dut.state);
      end
      spi_mode = 0;
      @(negedge clk);
   endtask

   task automatic test_spi_busy();
      int s, o, e;
      bit seen;
      apply_reset();
      spi_mode = 2;
      s = n_start; o = n_ok; e = n_err;
      send_good(2'd3, 8'h12);
      repeat (50) @(negedge clk);
      n_vec++;
      if (n_start != s || dut.state !== SEND) begin
         n_bad++;
         $display("FAIL busy_hold: got start %0d state %0d want 0 SEND", n_start - s, dut.state);
      end
      spi_mode = 0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (n_start != s) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin n_bad++; $display("FAIL busy_start: got no spi_start within 30 cycles"); end
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h55); send_byte(8'hF0);
      wait_idle("busy");
      repeat (5) @(negedge clk);
      n_vec++;
      if (n_start - s != 1 || n_ok - o != 1 || n_err != e || last_code !== 8'h12) begin
         n_bad++;
         $display("FAIL busy_ignore: got start %0d ok %0d err %0d code %h want 1 1 0 12",
                  n_start - s, n_ok - o, n_err - e, last_code);
      end
   endtask

   task automatic test_err_saturation();
      int e, o;
      apply_reset();
      send_good(2'd2, 8'h7F);
      wait_idle("sat");
      e = n_err;
      for (int i = 0; i < 300; i++) begin
         send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
      end
      n_vec++;
      if (n_err - e != 300 || err_cnt !== 8'd255) begin
         n_bad++;
         $display("FAIL sat_cnt: got pulses %0d cnt %0d want 300 255", n_err - e, err_cnt);
      end
      n_vec++;
      if (spi_data !== 10'h27F) begin n_bad++; $display("FAIL sat_hold: got %h want 27f", spi_data); end
      send_byte(8'hA5); send_byte(8'h01);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_vec++;
      if ({spi_data, spi_start, frame_ok, frame_err, err_cnt, last_code} !== 28'h0
          || dut.state !== IDLE) begin
         n_bad++;
         $display("FAIL async_reset: got %h state %0d want 0 IDLE",
                  {spi_data, spi_start, frame_ok, frame_err, err_cnt, last_code}, dut.state);
      end
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      o = n_ok;
      send_good(2'd0, 8'h81);
      wait_idle("rst");
      n_vec++;
      if (n_ok - o != 1 || spi_data !== 10'h081 || err_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL rst_next: got ok %0d data %h cnt %0d want 1 081 0",
                  n_ok - o, spi_data, err_cnt);
      end
   endtask

   task automatic test_reverse();
      int s, o;
      apply_reset();
      use_rev = 1'b1;
      s = n_start; o = n_ok;
      send_good(2'd2, 8'h7F);
      wait_idle("rev");
      n_vec++;
      if (n_start - s != 1 || n_ok - o != 1) begin
         n_bad++;
         $display("FAIL rev_count: got start %0d ok %0d want 1 1", n_start - s, n_ok - o);
      end
      n_vec++;
      if (spi_data_r !== 10'h27F || last_code_r !== 8'h7F || err_cnt_r !== 8'd0) begin
         n_bad++;
         $display("FAIL rev_data: got %h %h %0d want 27f 7f 0", spi_data_r, last_code_r, err_cnt_r);
      end
      use_rev = 1'b0;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_channel();
      test_timeout();
      test_spi_busy();
      test_err_saturation();
      test_reverse();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_left: got %0d queued words want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
